// File: rtl/mem_intf_mux_pkg.sv
// mem_intf_mux_pkg: shared defaults and helpers for the mem_intf N-to-1 mux
package mem_intf_mux_pkg;
    localparam int MEM_MUX_MAX_OUTSTANDING_DEFAULT = 2;
    typedef logic [31:0] perf_cnt_t;
    function automatic int mux_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_intf.sv
// mem_intf: request/grant memory port with decoupled read response channel
interface mem_intf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
    logic                  r_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    modport master (output req, addr, wen, data, be, r_ready, input gnt, r_valid, r_data);
    modport slave  (input req, addr, wen, data, be, r_ready, output gnt, r_valid, r_data);
endinterface

// File: rtl/mem_intf_mux_rr_idx_fifo.sv
// rr_idx_fifo: requester-index FIFO (push/pop/full/empty/head), sync active-high reset
module rr_idx_fifo
    import mem_intf_mux_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = mux_idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign head    = mem[rd_q];
    assign do_pop  = pop & ~empty;
    // a pop frees the slot the push writes into, so push-while-full is legal with a pop
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem[wr_q] <= din;
    end
endmodule

// File: rtl/mem_intf_mux.sv
// mem_intf_mux: round-robin N-to-1 mem_intf arbiter with in-order read response routing
//   clk_i/rst_i : clock, synchronous active-high reset
//   master_ports: NR_INPUTS upstream requesters; slave_port: merged downstream port
//   MEM_INTF_MUX_PERF_CNT_EN adds stall_cnt_o, per-input saturating stall counters
module mem_intf_mux
    import mem_intf_mux_pkg::*;
#(
    parameter int NR_INPUTS       = 4,
    parameter int MAX_OUTSTANDING = MEM_MUX_MAX_OUTSTANDING_DEFAULT,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    mem_intf.slave                        master_ports [NR_INPUTS],
    mem_intf.master                       slave_port
`ifdef MEM_INTF_MUX_PERF_CNT_EN
    ,
    output logic [NR_INPUTS-1:0][31:0]    stall_cnt_o
`endif
);
    localparam int IDX_WIDTH = $clog2(NR_INPUTS);
    logic [NR_INPUTS-1:0]  req, wen, r_ready, gnt;
    logic [ADDR_WIDTH-1:0] addr [NR_INPUTS];
    logic [DATA_WIDTH-1:0] data [NR_INPUTS];
    logic [BE_WIDTH-1:0]   be   [NR_INPUTS];
    logic [IDX_WIDTH-1:0]  rr_q, win, head;
    logic                  any, full, empty, pop, push, gate, s_req, accept, rsp_on;
    for (genvar i = 0; i < NR_INPUTS; i++) begin : g_port
        assign req[i]                  = master_ports[i].req;
        assign wen[i]                  = master_ports[i].wen;
        assign addr[i]                 = master_ports[i].addr;
        assign data[i]                 = master_ports[i].data;
        assign be[i]                   = master_ports[i].be;
        assign r_ready[i]              = master_ports[i].r_ready;
        assign gnt[i]                  = accept & (win == IDX_WIDTH'(i));
        assign master_ports[i].gnt     = gnt[i];
        assign master_ports[i].r_valid = rsp_on & (head == IDX_WIDTH'(i)) & slave_port.r_valid;
        assign master_ports[i].r_data  = (rsp_on && head == IDX_WIDTH'(i)) ? slave_port.r_data : '0;
    end
    // scan downwards so the requester closest to rr_q is written last and wins
    always_comb begin
        logic [IDX_WIDTH-1:0] idx;
        idx = '0;
        win = rr_q;
        any = 1'b0;
        for (int k = NR_INPUTS - 1; k >= 0; k--) begin
            idx = IDX_WIDTH'((int'(rr_q) + k) % NR_INPUTS);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    assign rsp_on  = ~rst_i & ~empty;
    assign pop     = ~empty & slave_port.r_valid & r_ready[head];
    // a stalled read keeps priority instead of letting lower-priority inputs pass it
    assign gate    = ~wen[win] & full & ~pop;
    assign s_req   = ~rst_i & any & ~gate;
    assign accept  = s_req & slave_port.gnt;
    assign push    = accept & ~wen[win];
    assign slave_port.req     = s_req;
    assign slave_port.addr    = any ? addr[win] : '0;
    assign slave_port.wen     = any ? wen[win] : 1'b1;
    assign slave_port.data    = any ? data[win] : '0;
    assign slave_port.be      = any ? be[win] : '0;
    assign slave_port.r_ready = rsp_on & r_ready[head];
    always_ff @(posedge clk_i) begin
        if (rst_i) rr_q <= '0;
        else if (accept) rr_q <= (win == IDX_WIDTH'(NR_INPUTS - 1)) ? '0 : win + 1'b1;
    end
    rr_idx_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(IDX_WIDTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (win),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
    // a response with nothing outstanding has no owner and is dropped
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(empty && slave_port.r_valid));
    end
`ifdef MEM_INTF_MUX_PERF_CNT_EN
    for (genvar i = 0; i < NR_INPUTS; i++) begin : g_perf
        always_ff @(posedge clk_i) begin
            if (rst_i) stall_cnt_o[i] <= '0;
            else if (req[i] && !gnt[i] && !(&stall_cnt_o[i])) stall_cnt_o[i] <= stall_cnt_o[i] + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_intf_mux.sv
// tb_mem_intf_mux: directed + random self-checking bench against a queue-based reference model
module tb_mem_intf_mux;
    localparam int N  = 4;
    localparam int MO = 2;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;
    logic [N-1:0] req = '0, wen = '1, rrdy = '1;
    logic [31:0]  addr [N];
    logic [31:0]  wdata [N];
    logic [3:0]   be [N];
    logic         s_gnt = 1'b0, s_rvalid = 1'b0;
    logic [31:0]  s_rdata = '0;
    logic [N-1:0] gnt_o, rv_o;
    logic [31:0]  rd_o [N];
`ifdef MEM_INTF_MUX_PERF_CNT_EN
    logic [N-1:0][31:0] stall_cnt;
`endif
    mem_intf m [N] ();
    mem_intf s ();
    for (genvar i = 0; i < N; i++) begin : g_drv
        assign m[i].req     = req[i];
        assign m[i].wen     = wen[i];
        assign m[i].addr    = addr[i];
        assign m[i].data    = wdata[i];
        assign m[i].be      = be[i];
        assign m[i].r_ready = rrdy[i];
        assign gnt_o[i]     = m[i].gnt;
        assign rv_o[i]      = m[i].r_valid;
        assign rd_o[i]      = m[i].r_data;
    end
    assign s.gnt     = s_gnt;
    assign s.r_valid = s_rvalid;
    assign s.r_data  = s_rdata;
    mem_intf_mux #(.NR_INPUTS(N), .MAX_OUTSTANDING(MO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .master_ports (m),
        .slave_port   (s)
`ifdef MEM_INTF_MUX_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt)
`endif
    );
    int           cmp_n = 0;
    int           bad_n = 0;
    int           rr = 0;
    int           q[$];
    int unsigned  sc [N];
    logic [N-1:0] last_gnt, last_rv;
    logic         last_sreq, last_srdy;
    function automatic logic [1:0] ix(input int v);
        return 2'(v);
    endfunction
    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // one clock cycle: check combinational outputs against the model, then advance the model
    task automatic step();
        int           w;
        bit           pop, fwd, acc, hv;
        logic [N-1:0] eg, erv;
        #1;
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && req[ix((rr + k) % N)]) w = (rr + k) % N;
        hv  = !rst_i && q.size() > 0;
        pop = q.size() > 0 && s_rvalid && rrdy[ix(q.size() > 0 ? q[0] : 0)];
        fwd = !rst_i && w >= 0 && (wen[ix(w)] || q.size() < MO || pop);
        acc = fwd && s_gnt;
        eg  = acc ? (N'(1) << w) : '0;
        erv = (hv && s_rvalid) ? (N'(1) << q[0]) : '0;
        cmp("slave_req", 64'(s.req), 64'(fwd));
        cmp("slave_addr", 64'(s.addr), 64'(w >= 0 ? addr[ix(w)] : 32'd0));
        cmp("slave_wen_be_data", 64'({s.wen, s.be, s.data}),
            64'(w >= 0 ? {wen[ix(w)], be[ix(w)], wdata[ix(w)]} : {1'b1, 4'd0, 32'd0}));
        cmp("gnt", 64'(gnt_o), 64'(eg));
        cmp("r_valid", 64'(rv_o), 64'(erv));
        cmp("slave_r_ready", 64'(s.r_ready), 64'(hv && rrdy[ix(q[0])]));
        for (int i = 0; i < N; i++)
            cmp($sformatf("r_data%0d", i), 64'(rd_o[i]), 64'((hv && q[0] == i) ? s_rdata : 32'd0));
        last_gnt  = gnt_o;
        last_rv   = rv_o;
        last_sreq = s.req;
        last_srdy = s.r_ready;
        @(posedge clk_i);
        if (rst_i) begin
            rr = 0;
            q.delete();
            for (int i = 0; i < N; i++) sc[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) if (req[i] && !eg[i] && sc[i] != 32'hFFFF_FFFF) sc[i]++;
            if (pop) void'(q.pop_front());
            if (acc) begin
                rr = (w + 1) % N;
                if (!wen[ix(w)]) q.push_back(w);
            end
        end
        #1;
    endtask
    initial begin
        for (int i = 0; i < N; i++) begin
            addr[i]  = 32'h1000 * (i + 1);
            wdata[i] = $urandom;
            be[i]    = 4'(i + 1);
            sc[i]    = 0;
        end
        step();
        step();
        rst_i = 1'b0;
        // fairness: three readers, one response per cycle
        req = 4'b0111; wen = 4'b1000; s_gnt = 1'b1; rrdy = '1;
        for (int n = 0; n < 6; n++) begin
            s_rvalid = q.size() > 0;
            s_rdata  = $urandom;
            step();
            cmp("fair_order", 64'(last_gnt), 64'(N'(1) << (n % 3)));
        end
        // move the pointer to input 3, then stall a write on it while input 0 waits
        req = 4'b0100; wen = '1; s_rvalid = 1'b1; s_rdata = $urandom;
        step();
        s_rvalid = 1'b0; req = 4'b1001; s_gnt = 1'b0; addr[3] = $urandom;
        for (int n = 0; n < 5; n++) begin
            step();
            cmp("stall_hold_addr", 64'(s.addr), 64'(addr[3]));
        end
        s_gnt = 1'b1;
        step();
        cmp("stall_release_gnt3", 64'(last_gnt), 64'(4'b1000));
        step();
        cmp("after_stall_gnt0", 64'(last_gnt), 64'(4'b0001));
        // fill the FIFO with two reads, then check gating
        wen = 4'b1000; req = 4'b0001;
        step();
        req = 4'b0010;
        step();
        req = 4'b0100;
        step();
        cmp("full_gate_req", 64'(last_sreq), 64'(1'b0));
        req = 4'b1000;
        step();
        cmp("full_write_passes", 64'(last_gnt), 64'(4'b1000));
        req = 4'b0100;
        step();
        cmp("full_gate_again", 64'(last_sreq), 64'(1'b0));
        s_rvalid = 1'b1; s_rdata = $urandom;
        step();
        cmp("full_pop_forward", 64'({last_sreq, last_gnt}), 64'({1'b1, 4'b0100}));
        // response backpressure on head input 1
        req = '0; rrdy = 4'b1101;
        for (int n = 0; n < 3; n++) begin
            s_rdata = $urandom;
            step();
            cmp("bp_r_ready", 64'(last_srdy), 64'(1'b0));
        end
        rrdy = '1; s_rdata = $urandom;
        step();
        s_rdata = $urandom;
        step();
        cmp("bp_next_head", 64'(last_rv), 64'(4'b0100));
        s_rvalid = 1'b0;
        // reset with two reads outstanding
        req = 4'b0011;
        step();
        step();
        rst_i = 1'b1; req = '0;
        step();
        rst_i = 1'b0;
        step();
        cmp("post_rst_rvalid", 64'(rv_o), 64'(0));
        req = 4'b0011;
        step();
        cmp("post_rst_gnt0", 64'(last_gnt), 64'(4'b0001));
        req = '0; s_rvalid = 1'b1; s_rdata = $urandom;
        step();
        s_rvalid = 1'b0;
`ifdef MEM_INTF_MUX_PERF_CNT_EN
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; req = 4'b0010; s_gnt = 1'b0;
        repeat (7) step();
        for (int i = 0; i < N; i++) cmp($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i]), 64'(i == 1 ? 7 : 0));
        req = '0; s_gnt = 1'b1;
`endif
        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst_i    = ($urandom_range(99) == 0);
            req      = 4'($urandom);
            wen      = 4'($urandom);
            rrdy     = 4'($urandom);
            s_gnt    = 1'($urandom);
            s_rvalid = q.size() > 0 && 1'($urandom);
            s_rdata  = $urandom;
            for (int i = 0; i < N; i++) begin
                addr[i]  = $urandom;
                wdata[i] = $urandom;
                be[i]    = 4'($urandom);
            end
            step();
        end
`ifdef MEM_INTF_MUX_PERF_CNT_EN
        for (int i = 0; i < N; i++) cmp($sformatf("stall_cnt_rand%0d", i), 64'(stall_cnt[i]), 64'(sc[i]));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end
endmodule
